pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 40 ++++
 rtl/hazard_detect.sv | 13 +
 rtl/pipeline_ctrl.sv | 103 ++++++++++
 tb/tb_pipeline_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: FSM encoding, drain length and the
// per-cycle control bundle driven into the IF/ID and ID/EX stages.
package pipeline_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int DRAIN_CYC_DEF = 4;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, bubble: 1'b1};
    localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, bubble: 1'b1};
    localparam ctrl_t CTRL_DRAIN = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, bubble: 1'b0};

    // Stall beats redirect: a branch that collides with a load-use hazard is
    // re-evaluated once the bubble has resolved the operand.
    function automatic ctrl_t ctrl_decode(input logic [1:0] state,
                                          input logic       hz,
                                          input logic       redirect);
        ctrl_t c;
        c = CTRL_IDLE;
        case (state)
            ST_RUN: begin
                if (hz) c = CTRL_STALL;
                else    c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: redirect, bubble: 1'b0};
            end
            ST_DRAIN: c = CTRL_DRAIN;
            default:  c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the operands in IF/ID.
module hazard_detect (
    input  logic       memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hz
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hz = memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: IDLE/RUN/DRAIN sequencing, stall/flush steering and
// saturating stall/flush event counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             id_jump_i,
    input  logic             id_br_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             bubble_o,
    output logic             run_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Down-counter runs DRAIN_CYC-1 .. 0, giving exactly DRAIN_CYC drain cycles.
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYC - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [2:0]       drain_cnt;
    logic             hz;
    logic             redirect;
    logic             stall_evt;
    logic             flush_evt;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    hazard_detect u_hazard (
        .memread (ex_memread_i),
        .ex_rt   (ex_rt_i),
        .id_rs   (id_rs_i),
        .id_rt   (id_rt_i),
        .hz      (hz)
    );

    assign redirect = id_jump_i | id_br_taken_i;

    always_comb begin
        ctrl = ctrl_decode(state, hz, redirect);
    end

    assign pc_write_o   = ctrl.pc_write;
    assign ifid_write_o = ctrl.ifid_write;
    assign ifid_flush_o = ctrl.ifid_flush;
    assign bubble_o     = ctrl.bubble;
    assign run_o        = (state == ST_RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i)            state_nxt = ST_RUN;
            ST_RUN:   if (!start_i)           state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == 3'd0)  state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            drain_cnt <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_RUN && !start_i)
                drain_cnt <= DRAIN_LOAD;
            else if (state == ST_DRAIN && drain_cnt != 3'd0)
                drain_cnt <= drain_cnt - 3'd1;
        end
    end

    // Only RUN cycles are counted; drain flushes are housekeeping, not events.
    assign stall_evt = (state == ST_RUN) && hz;
    assign flush_evt = (state == ST_RUN) && ctrl.ifid_flush;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares. A 2-bit-counter copy covers saturation.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rt = '0;
    logic        id_jump = 1'b0;
    logic        id_br_taken = 1'b0;

    logic        pc_write, ifid_write, ifid_flush, bubble, run;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_bubble, s_run;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .id_jump_i(id_jump), .id_br_taken_i(id_br_taken),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .bubble_o(bubble), .run_o(run), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .id_jump_i(id_jump), .id_br_taken_i(id_br_taken),
        .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
        .bubble_o(s_bubble), .run_o(s_run), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    typedef struct {
        string      name;
        logic [3:0] ctl;   // {pc_write, ifid_write, ifid_flush, bubble}
        logic [3:0] mask;
        logic       run;
        int         stall;
        int         flush;
        int         sat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s.%s got=%0d expected=%0d", nm, field, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "ctrl", int'({pc_write, ifid_write, ifid_flush, bubble} & e.mask), int'(e.ctl & e.mask));
                chk(e.name, "run", int'(run), int'(e.run));
                chk(e.name, "stall_cnt", int'(stall_cnt), e.stall);
                chk(e.name, "flush_cnt", int'(flush_cnt), e.flush);
                chk(e.name, "sat_ctrl", int'({s_pc_write, s_ifid_write, s_ifid_flush, s_bubble} & e.mask), int'(e.ctl & e.mask));
                chk(e.name, "sat_run", int'(s_run), int'(e.run));
                chk(e.name, "sat_stall", int'(s_stall_cnt), e.sat);
                chk(e.name, "sat_flush", int'(s_flush_cnt), (e.flush > 3) ? 3 : e.flush);
            end
        end
    end

    // One vector per cycle, applied just after the rising edge.
    task automatic step(input string nm, input logic r, input logic s, input logic mr,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input logic j, input logic b, input logic [3:0] ectl, input logic iw_care,
                        input logic erun, input int est, input int efl, input int esat);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; start = s; ex_memread = mr; ex_rt = ert;
        id_rs = rs; id_rt = rt; id_jump = j; id_br_taken = b;
        e.name = nm; e.ctl = ectl; e.mask = iw_care ? 4'b1111 : 4'b1011;
        e.run = erun; e.stall = est; e.flush = efl; e.sat = esat;
        q.push_back(e);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        //   name            r  s  mr ert rs rt j  b  ctl      iw run st fl sat
        step("reset",        0, 0, 0, 0,  0, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0);
        step("idle_start",   1, 1, 0, 0,  0, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0);
        step("run_entry",    1, 1, 0, 0,  0, 0, 0, 0, 4'b1100, 1, 1, 0, 0, 0);
        step("loaduse_rs",   1, 1, 1, 8,  8, 0, 0, 0, 4'b0001, 1, 1, 0, 0, 0);
        step("stall_counted",1, 1, 0, 0,  0, 0, 0, 0, 4'b1100, 1, 1, 1, 0, 1);
        step("rt_zero",      1, 1, 1, 0,  0, 0, 0, 0, 4'b1100, 1, 1, 1, 0, 1);
        step("rt_zero_cnt",  1, 1, 0, 0,  0, 0, 0, 0, 4'b1100, 1, 1, 1, 0, 1);
        step("br_vs_hz",     1, 1, 1, 9,  0, 9, 0, 1, 4'b0001, 1, 1, 1, 0, 1);
        step("br_flush",     1, 1, 0, 9,  0, 9, 0, 1, 4'b1110, 1, 1, 2, 0, 2);
        step("flush_counted",1, 1, 0, 0,  0, 0, 0, 0, 4'b1100, 1, 1, 2, 1, 2);
        step("jump_flush",   1, 1, 0, 0,  0, 0, 1, 0, 4'b1110, 1, 1, 2, 1, 2);
        step("no_memread",   1, 1, 0, 5,  5, 0, 0, 0, 4'b1100, 1, 1, 2, 2, 2);
        step("stop_req",     1, 0, 0, 0,  0, 0, 0, 0, 4'b1100, 1, 1, 2, 2, 2);
        step("drain1",       1, 1, 1, 4,  4, 0, 0, 0, 4'b0010, 0, 0, 2, 2, 2);
        step("drain2",       1, 1, 0, 0,  0, 0, 0, 1, 4'b0010, 0, 0, 2, 2, 2);
        step("drain3",       1, 0, 0, 0,  0, 0, 1, 0, 4'b0010, 0, 0, 2, 2, 2);
        step("drain4",       1, 1, 0, 0,  0, 0, 0, 0, 4'b0010, 0, 0, 2, 2, 2);
        step("idle_after",   1, 0, 1, 4,  4, 0, 0, 1, 4'b0001, 1, 0, 2, 2, 2);
        step("restart",      1, 1, 0, 0,  0, 0, 0, 0, 4'b0001, 1, 0, 2, 2, 2);
        step("sat_stall1",   1, 1, 1, 3,  3, 0, 0, 0, 4'b0001, 1, 1, 2, 2, 2);
        step("sat_stall2",   1, 1, 1, 3,  3, 0, 0, 0, 4'b0001, 1, 1, 3, 2, 3);
        step("sat_stall3",   1, 1, 1, 3,  0, 3, 0, 0, 4'b0001, 1, 1, 4, 2, 3);
        step("sat_stall4",   1, 1, 1, 3,  3, 3, 0, 0, 4'b0001, 1, 1, 5, 2, 3);
        step("sat_hold",     1, 1, 0, 0,  0, 0, 0, 0, 4'b1100, 1, 1, 6, 2, 3);
        step("stop2",        1, 0, 0, 0,  0, 0, 0, 0, 4'b1100, 1, 1, 6, 2, 3);
        step("drain_mid",    1, 0, 0, 0,  0, 0, 0, 0, 4'b0010, 0, 0, 6, 2, 3);
        step("rst_mid_drain",0, 0, 0, 0,  0, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0);
        step("rst_release",  1, 0, 0, 0,  0, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0);
        step("need_start",   1, 1, 0, 0,  0, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0);
        step("rerun",        1, 1, 0, 0,  0, 0, 0, 0, 4'b1100, 1, 1, 0, 0, 0);

        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
